// File: rtl/m65c02_bus_waitgen_if.sv
// Bus bundle between the M65C02 core, the wait-state generator and external memory/IO.
// master = core/board side, slave = m65c02_bus_waitgen.
interface m65c02_bus_waitgen_if;
  logic [1:0]  IO_Op;
  logic [15:0] AO;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        Wait;
  logic [15:0] XA;
  logic [7:0]  XDO;
  logic        XDO_OE;
  logic [7:0]  XDI;
  logic        nCE_ROM;
  logic        nCE_RAM;
  logic        nCE_IO;
  logic        nOE;
  logic        nWE;
  logic        xWait;
  logic        BusErr;
  logic        Clr_BusErr;

  modport master (
    output IO_Op, AO, DO, XDI, xWait, Clr_BusErr,
    input  DI, Wait, XA, XDO, XDO_OE, nCE_ROM, nCE_RAM, nCE_IO, nOE, nWE, BusErr
  );

  modport slave (
    input  IO_Op, AO, DO, XDI, xWait, Clr_BusErr,
    output DI, Wait, XA, XDO, XDO_OE, nCE_ROM, nCE_RAM, nCE_IO, nOE, nWE, BusErr
  );
endinterface

// File: rtl/m65c02_bus_waitgen.sv
// M65C02 bus interface: region decode, per-region wait states, async SRAM/IO strobes
// and an IO bus-error timeout for cycles stretched indefinitely by xWait.
module m65c02_bus_waitgen #(
  parameter logic [15:0] pROM_Base = 16'hF000,
  parameter logic [15:0] pIO_Base  = 16'hEF00,
  parameter int          pROM_WS   = 1,
  parameter int          pRAM_WS   = 0,
  parameter int          pIO_WS    = 2,
  parameter int          pTimeout  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  m65c02_bus_waitgen_if.slave    bus
);

  localparam logic [2:0] LP_ROM_WS  = 3'(pROM_WS);
  localparam logic [2:0] LP_RAM_WS  = 3'(pRAM_WS);
  localparam logic [2:0] LP_IO_WS   = 3'(pIO_WS);
  localparam logic [7:0] LP_TIMEOUT = 8'(pTimeout);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EXT  = 2'd2
  } state_t;

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_tcnt, w_tcnt_nxt;
  logic       r_buserr;
  logic       w_wait, w_set_err, w_timeout;

  logic       w_active, w_write, w_read;
  logic       w_io, w_rom, w_ram, w_xw;
  logic [2:0] w_ws_base, w_n;

  assign w_active = (bus.IO_Op != 2'b00);
  assign w_write  = (bus.IO_Op == 2'b01);
  assign w_read   = bus.IO_Op[1];

  // IO page wins over ROM, ROM over RAM.
  assign w_io  = (bus.AO[15:8] == pIO_Base[15:8]);
  assign w_rom = !w_io && (bus.AO >= pROM_Base);
  assign w_ram = !w_io && !w_rom;
  assign w_xw  = w_io && bus.xWait;

  assign w_ws_base = w_io ? LP_IO_WS : (w_rom ? LP_ROM_WS : LP_RAM_WS);
  // Writes need at least one cycle of address setup before nWE falls.
  assign w_n = (w_write && (w_ws_base == 3'd0)) ? 3'd1 : w_ws_base;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_tcnt   <= 8'd0;
      r_buserr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_set_err)
        r_buserr <= 1'b1;
      else if (bus.Clr_BusErr)
        r_buserr <= 1'b0;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_tcnt_nxt = r_tcnt;
    w_wait     = 1'b0;
    w_set_err  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_active && (w_n != 3'd0)) begin
          w_wait    = 1'b1;
          w_cnt_nxt = 3'd1;
          w_next    = S_ACC;
        end
      end
      S_ACC: begin
        if (!w_active) begin
          w_next    = S_IDLE;
          w_cnt_nxt = 3'd0;
        end else if (r_cnt < w_n) begin
          w_wait    = 1'b1;
          w_cnt_nxt = r_cnt + 3'd1;
        end else if (w_xw) begin
          w_wait     = 1'b1;
          w_next     = S_EXT;
          w_cnt_nxt  = 3'd0;
          w_tcnt_nxt = 8'd1;
        end else begin
          w_next    = S_IDLE;
          w_cnt_nxt = 3'd0;
        end
      end
      S_EXT: begin
        if (!w_active || !w_xw) begin
          w_next     = S_IDLE;
          w_tcnt_nxt = 8'd0;
        end else if (r_tcnt >= LP_TIMEOUT) begin
          // Abort: release the core with 8'hFF and flag the error.
          w_next     = S_IDLE;
          w_tcnt_nxt = 8'd0;
          w_set_err  = 1'b1;
          w_timeout  = 1'b1;
        end else begin
          w_wait     = 1'b1;
          w_tcnt_nxt = r_tcnt + 8'd1;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_nxt  = 3'd0;
        w_tcnt_nxt = 8'd0;
      end
    endcase
  end

  // All bus outputs are held inactive/zero while reset is asserted.
  assign bus.Wait    = !i_rst && w_wait;
  assign bus.XA      = i_rst ? 16'h0000 : bus.AO;
  assign bus.XDO     = i_rst ? 8'h00 : bus.DO;
  assign bus.XDO_OE  = !i_rst && w_write;
  assign bus.DI      = i_rst ? 8'h00 : (w_timeout ? 8'hFF : bus.XDI);
  assign bus.nCE_ROM = !(!i_rst && w_active && w_rom);
  assign bus.nCE_RAM = !(!i_rst && w_active && w_ram);
  assign bus.nCE_IO  = !(!i_rst && w_active && w_io);
  assign bus.nOE     = !(!i_rst && w_read);
  assign bus.nWE     = !(!i_rst && w_write && !w_rom && (r_state != S_IDLE));
  assign bus.BusErr  = r_buserr;

endmodule

// File: tb/tb_m65c02_bus_waitgen.sv
// Self-checking bench for m65c02_bus_waitgen: directed scenarios plus randomized
// accesses compared against a cycle-count model of the wait-state rules.
module tb_m65c02_bus_waitgen;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  bit   berr_m;

  m65c02_bus_waitgen_if bif();

  m65c02_bus_waitgen dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_io(input logic [15:0] a);
    return a[15:8] == 8'hEF;
  endfunction

  function automatic bit is_rom(input logic [15:0] a);
    return !is_io(a) && (a >= 16'hF000);
  endfunction

  function automatic int model_n(input logic [1:0] op, input logic [15:0] a);
    int n;
    n = is_io(a) ? 2 : (is_rom(a) ? 1 : 0);
    if (op == 2'b01 && n == 0) n = 1;
    return n;
  endfunction

  // Wait cycles before completion; xWait is held for k cycles starting when cnt reaches N.
  function automatic int model_wait(input logic [1:0] op, input logic [15:0] a,
                                    input int k, output bit tmo);
    int n;
    n   = model_n(op, a);
    tmo = 1'b0;
    if (is_io(a) && k > 0) begin
      if (k > 64) begin
        tmo = 1'b1;
        return n + 64;
      end
      return n + k;
    end
    return n;
  endfunction

  // {nCE_ROM, nCE_RAM, nCE_IO, nOE, nWE, XDO_OE}
  function automatic logic [5:0] exp_strb(input logic [1:0] op, input logic [15:0] a,
                                          input bit first);
    bit act, io, rom;
    act = (op != 2'b00);
    io  = is_io(a);
    rom = is_rom(a);
    return {!(act && rom), !(act && !io && !rom), !(act && io), !op[1],
            !(op == 2'b01 && !rom && !first), op == 2'b01};
  endfunction

  function automatic logic [5:0] strb();
    return {bif.nCE_ROM, bif.nCE_RAM, bif.nCE_IO, bif.nOE, bif.nWE, bif.XDO_OE};
  endfunction

  task automatic idle(input int n);
    bif.IO_Op      = 2'b00;
    bif.xWait      = 1'b0;
    bif.Clr_BusErr = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives one access until Wait drops (bounded), returning what was observed.
  task automatic run_access(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] xdi, input int k, input logic clr,
                            output int wcyc, output logic [7:0] di, output logic [5:0] s0,
                            output logic [5:0] slast, output logic [7:0] xdo,
                            output logic berr);
    int n;
    n     = model_n(op, a);
    wcyc  = -1;
    di    = 8'hxx;
    s0    = 6'hxx;
    slast = 6'hxx;
    xdo   = 8'hxx;
    berr  = 1'bx;
    for (int c = 0; c < 300; c++) begin
      bif.IO_Op      = op;
      bif.AO         = a;
      bif.DO         = d;
      bif.XDI        = xdi;
      bif.Clr_BusErr = clr;
      bif.xWait      = is_io(a) ? (c >= n && c < n + k) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) s0 = strb();
      if (!bif.Wait) begin
        wcyc  = c;
        di    = bif.DI;
        slast = strb();
        xdo   = bif.XDO;
        @(posedge clk); #1;
        berr  = bif.BusErr;
        break;
      end
      @(posedge clk); #1;
    end
    if (wcyc < 0) berr = bif.BusErr;
    bif.Clr_BusErr = 1'b0;
    bif.xWait      = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bif.IO_Op = 2'b10;
    bif.AO    = 16'h0200;
    @(negedge clk);
    n_chk++; if (strb() !== 6'b111110) $display("FAIL rst_strb_in_reset got %b exp %b", strb(), 6'b111110); else n_pass++;
    n_chk++; if (bif.Wait !== 1'b0) $display("FAIL rst_wait_in_reset got %b exp 0", bif.Wait); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0);
    @(negedge clk);
    n_chk++; if (strb() !== 6'b111110) $display("FAIL rst_strb got %b exp %b", strb(), 6'b111110); else n_pass++;
    n_chk++; if (bif.Wait !== 1'b0) $display("FAIL rst_wait got %b exp 0", bif.Wait); else n_pass++;
    n_chk++; if (bif.BusErr !== 1'b0) $display("FAIL rst_buserr got %b exp 0", bif.BusErr); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ram_read();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    run_access(2'b10, 16'h0200, 8'h00, 8'h5A, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 0) $display("FAIL ram_rd_wait got %0d exp 0", w); else n_pass++;
    n_chk++; if (sl !== exp_strb(2'b10, 16'h0200, 1)) $display("FAIL ram_rd_strb got %b exp %b", sl, exp_strb(2'b10, 16'h0200, 1)); else n_pass++;
    n_chk++; if (di !== 8'h5A) $display("FAIL ram_rd_di got %h exp 5a", di); else n_pass++;
    idle(1);
  endtask

  task automatic test_rom_fetch();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    run_access(2'b11, 16'hFFFC, 8'h00, 8'h3C, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 1) $display("FAIL rom_fetch_wait got %0d exp 1", w); else n_pass++;
    n_chk++; if (s0 !== 6'b011010) $display("FAIL rom_fetch_strb0 got %b exp 011010", s0); else n_pass++;
    n_chk++; if (sl !== 6'b011010) $display("FAIL rom_fetch_strb1 got %b exp 011010", sl); else n_pass++;
    n_chk++; if (di !== 8'h3C) $display("FAIL rom_fetch_di got %h exp 3c", di); else n_pass++;
  endtask

  task automatic test_writes();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    run_access(2'b01, 16'h0010, 8'hA5, 8'h00, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 1) $display("FAIL ram_wr_wait got %0d exp 1", w); else n_pass++;
    n_chk++; if (s0 !== 6'b101111) $display("FAIL ram_wr_strb0 got %b exp 101111", s0); else n_pass++;
    n_chk++; if (sl !== 6'b101101) $display("FAIL ram_wr_strb1 got %b exp 101101", sl); else n_pass++;
    n_chk++; if (xdo !== 8'hA5) $display("FAIL ram_wr_xdo got %h exp a5", xdo); else n_pass++;
    run_access(2'b01, 16'hF000, 8'h77, 8'h00, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 1) $display("FAIL rom_wr_wait got %0d exp 1", w); else n_pass++;
    n_chk++; if (sl !== 6'b011111) $display("FAIL rom_wr_nwe got %b exp 011111", sl); else n_pass++;
    idle(1);
  endtask

  task automatic test_io_xwait();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    run_access(2'b10, 16'hEF03, 8'h00, 8'hC3, 5, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 7) $display("FAIL io_xwait_wait got %0d exp 7", w); else n_pass++;
    n_chk++; if (di !== 8'hC3) $display("FAIL io_xwait_di got %h exp c3", di); else n_pass++;
    n_chk++; if (be !== 1'b0) $display("FAIL io_xwait_buserr got %b exp 0", be); else n_pass++;
    idle(1);
  endtask

  task automatic test_timeout();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    run_access(2'b10, 16'hEF40, 8'h00, 8'h12, 1000, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 66) $display("FAIL tmo_wait got %0d exp 66", w); else n_pass++;
    n_chk++; if (di !== 8'hFF) $display("FAIL tmo_di got %h exp ff", di); else n_pass++;
    n_chk++; if (be !== 1'b1) $display("FAIL tmo_buserr got %b exp 1", be); else n_pass++;
    idle(3);
    n_chk++; if (bif.BusErr !== 1'b1) $display("FAIL tmo_buserr_sticky got %b exp 1", bif.BusErr); else n_pass++;
    bif.Clr_BusErr = 1'b1;
    @(posedge clk); #1;
    bif.Clr_BusErr = 1'b0;
    n_chk++; if (bif.BusErr !== 1'b0) $display("FAIL tmo_buserr_clr got %b exp 0", bif.BusErr); else n_pass++;
    // Clear held through a second timeout: the set in the completing cycle must win.
    run_access(2'b11, 16'hEFFF, 8'h00, 8'h12, 1000, 1'b1, w, di, s0, sl, xdo, be);
    n_chk++; if (be !== 1'b1) $display("FAIL tmo_set_over_clr got %b exp 1", be); else n_pass++;
    idle(1);
    berr_m = 1'b1;
  endtask

  task automatic test_rst_mid();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    bif.IO_Op = 2'b01; bif.AO = 16'hEF10; bif.DO = 8'h99;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bif.IO_Op = 2'b00;
    @(negedge clk);
    n_chk++; if (strb() !== 6'b111110) $display("FAIL rst_mid_strb got %b exp 111110", strb()); else n_pass++;
    n_chk++; if (bif.Wait !== 1'b0) $display("FAIL rst_mid_wait got %b exp 0", bif.Wait); else n_pass++;
    n_chk++; if (bif.BusErr !== 1'b0) $display("FAIL rst_mid_buserr got %b exp 0", bif.BusErr); else n_pass++;
    berr_m = 1'b0;
    @(posedge clk); #1;
    run_access(2'b10, 16'h0300, 8'h00, 8'h6E, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 0 || di !== 8'h6E) $display("FAIL rst_mid_ram_rd got w=%0d di=%h exp w=0 di=6e", w, di); else n_pass++;
    // Reset again mid-access, then launch a ROM fetch straight away: FSM must start from IDLE.
    bif.IO_Op = 2'b01; bif.AO = 16'hEF10;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_access(2'b11, 16'hF800, 8'h00, 8'h21, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 1) $display("FAIL rst_mid_rom_wait got %0d exp 1", w); else n_pass++;
    idle(1);
  endtask

  task automatic test_op_drop();
    int w; logic [7:0] di, xdo; logic [5:0] s0, sl; logic be;
    bif.IO_Op = 2'b10; bif.AO = 16'hEF20; bif.xWait = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.IO_Op = 2'b00;
    @(negedge clk);
    n_chk++; if (bif.Wait !== 1'b0 || strb() !== 6'b111110) $display("FAIL op_drop_idle got wait=%b strb=%b exp 0 111110", bif.Wait, strb()); else n_pass++;
    @(posedge clk); #1;
    run_access(2'b11, 16'hF123, 8'h00, 8'h44, 0, 1'b0, w, di, s0, sl, xdo, be);
    n_chk++; if (w !== 1) $display("FAIL op_drop_next_wait got %0d exp 1", w); else n_pass++;
  endtask

  task automatic test_random();
    int w, ew, k, sel; bit tmo; logic [1:0] op; logic [15:0] a; logic [7:0] d, x;
    logic [7:0] di, xdo; logic [5:0] s0, sl; logic be, clr;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      a   = (sel == 0) ? {8'hEF, 8'($urandom)} :
            (sel == 1) ? (16'hF000 | 16'($urandom_range(0, 16'h0FFF))) :
                         16'($urandom_range(0, 16'hEEFF));
      op  = 2'($urandom_range(1, 3));
      d   = 8'($urandom);
      x   = 8'($urandom);
      k   = $urandom_range(0, 9);
      if (k == 9) k = 65 + $urandom_range(0, 10);
      clr = ($urandom_range(0, 7) == 0);
      ew  = model_wait(op, a, k, tmo);
      run_access(op, a, d, x, k, clr, w, di, s0, sl, xdo, be);
      berr_m = tmo | (berr_m & !clr);
      n_chk++; if (w !== ew) $display("FAIL rnd_wait i=%0d op=%b a=%h k=%0d got %0d exp %0d", i, op, a, k, w, ew); else n_pass++;
      n_chk++; if (s0 !== exp_strb(op, a, 1)) $display("FAIL rnd_strb0 i=%0d got %b exp %b", i, s0, exp_strb(op, a, 1)); else n_pass++;
      n_chk++; if (sl !== exp_strb(op, a, ew == 0)) $display("FAIL rnd_strb_last i=%0d got %b exp %b", i, sl, exp_strb(op, a, ew == 0)); else n_pass++;
      n_chk++; if (be !== berr_m) $display("FAIL rnd_buserr i=%0d got %b exp %b", i, be, berr_m); else n_pass++;
      if (op[1]) begin
        n_chk++; if (di !== (tmo ? 8'hFF : x)) $display("FAIL rnd_di i=%0d got %h exp %h", i, di, tmo ? 8'hFF : x); else n_pass++;
      end else begin
        n_chk++; if (xdo !== d) $display("FAIL rnd_xdo i=%0d got %h exp %h", i, xdo, d); else n_pass++;
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; berr_m = 1'b0;
    rst = 1'b1;
    bif.IO_Op = 2'b00; bif.AO = 16'h0000; bif.DO = 8'h00; bif.XDI = 8'h00;
    bif.xWait = 1'b0; bif.Clr_BusErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ram_read();
    test_rom_fetch();
    test_writes();
    test_io_xwait();
    test_timeout();
    test_rst_mid();
    test_op_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
